// File: rtl/snax_csr_responder.sv
// CSR endpoint of the accelerator shell: owns the RW configuration bank, serves reads
// through a one-entry response register and sequences accelerator launches.
//
// state      | meaning
// -----------+---------------------------------------------------------
// StIdle     | no run in progress; configuration bank writable
// StLaunch   | acc_start_o pulses, run counter cleared
// StWaitBusy | waiting for the accelerator to raise acc_busy_i
// StRun      | accelerator busy; run counter counting
module snax_csr_responder #(
   parameter int unsigned NumRwCsr  = 8,
   parameter int unsigned NumRoCsr  = 2,
   parameter int unsigned DataWidth = 32
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [DataWidth-1:0]          csr_req_data_i,
   input  logic [31:0]                   csr_req_addr_i,
   input  logic                          csr_req_write_i,
   input  logic                          csr_req_valid_i,
   output logic                          csr_req_ready_o,
   output logic [DataWidth-1:0]          csr_rsp_data_o,
   output logic                          csr_rsp_valid_o,
   input  logic                          csr_rsp_ready_i,
   output logic [NumRwCsr*DataWidth-1:0] csr_rw_o,
   input  logic [NumRoCsr*DataWidth-1:0] csr_ro_i,
   output logic                          acc_start_o,
   input  logic                          acc_busy_i
);

   localparam logic [31:0] CtrlAddr = 32'(NumRwCsr + NumRoCsr);
   localparam logic [31:0] CntAddr  = CtrlAddr + 32'd1;

   typedef enum logic [1:0] {StIdle, StLaunch, StWaitBusy, StRun} state_e;

   state_e               state_q, state_d;
   logic [DataWidth-1:0] cnt_q, cnt_d;
   logic [DataWidth-1:0] rw_q [NumRwCsr];
   logic [DataWidth-1:0] rw_d [NumRwCsr];
   logic                 rsp_valid_q, rsp_valid_d;
   logic [DataWidth-1:0] rsp_data_q, rsp_data_d;

   logic                 is_rw, is_ctrl, is_cnt;
   logic                 req_acc, rd_acc, wr_acc, launch;
   logic [DataWidth-1:0] rd_data;

   assign is_rw   = csr_req_addr_i < 32'(NumRwCsr);
   assign is_ctrl = csr_req_addr_i == CtrlAddr;
   assign is_cnt  = csr_req_addr_i == CntAddr;

   // Reads only stall on a held response; bank and control writes are locked outside IDLE.
   always_comb begin
      csr_req_ready_o = 1'b1;
      if (!csr_req_write_i) begin
         csr_req_ready_o = !rsp_valid_q || csr_rsp_ready_i;
      end else if (is_rw || is_ctrl) begin
         csr_req_ready_o = (state_q == StIdle);
      end
   end

   assign req_acc = csr_req_valid_i && csr_req_ready_o;
   assign rd_acc  = req_acc && !csr_req_write_i;
   assign wr_acc  = req_acc && csr_req_write_i;
   assign launch  = wr_acc && is_ctrl && csr_req_data_i[0];

   always_comb begin
      rd_data = '0;
      for (int k = 0; k < int'(NumRwCsr); k++) begin
         if (csr_req_addr_i == 32'(k)) rd_data = rw_q[k];
      end
      for (int k = 0; k < int'(NumRoCsr); k++) begin
         if (csr_req_addr_i == 32'(int'(NumRwCsr) + k)) begin
            rd_data = csr_ro_i[k*DataWidth +: DataWidth];
         end
      end
      if (is_ctrl) rd_data[1:0] = {state_q == StRun, state_q != StIdle};
      if (is_cnt)  rd_data = cnt_q;
   end

   always_comb begin
      rw_d = rw_q;
      for (int k = 0; k < int'(NumRwCsr); k++) begin
         if (wr_acc && csr_req_addr_i == 32'(k)) rw_d[k] = csr_req_data_i;
      end
   end

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      if (rd_acc) begin
         rsp_valid_d = 1'b1;
         rsp_data_d  = rd_data;
      end else if (csr_rsp_ready_i) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_start_o = 1'b0;
      case (state_q)
         StIdle: begin
            if (launch) state_d = StLaunch;
         end
         StLaunch: begin
            acc_start_o = 1'b1;
            cnt_d       = '0;
            state_d     = StWaitBusy;
         end
         StWaitBusy: begin
            if (acc_busy_i) state_d = StRun;
         end
         StRun: begin
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            if (!acc_busy_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         for (int k = 0; k < int'(NumRwCsr); k++) rw_q[k] <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         for (int k = 0; k < int'(NumRwCsr); k++) rw_q[k] <= rw_d[k];
      end
   end

   always_comb begin
      csr_rw_o = '0;
      for (int k = 0; k < int'(NumRwCsr); k++) csr_rw_o[k*DataWidth +: DataWidth] = rw_q[k];
   end

   assign csr_rsp_valid_o = rsp_valid_q;
   assign csr_rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_snax_csr_responder.sv
// Bench for snax_csr_responder: directed scenarios plus random traffic, all checked
// cycle by cycle against a behavioural model of the CSR endpoint.
module tb_snax_csr_responder;

   localparam int M_IDLE = 0, M_LAUNCH = 1, M_WAIT = 2, M_RUN = 3;

   logic         clk = 1'b0;
   logic         rst, req_valid, req_write, req_ready, rsp_valid, rsp_ready, start, busy;
   logic [31:0]  req_data, req_addr, rsp_data;
   logic [255:0] rw_o;
   logic [63:0]  ro, ro_nxt;

   always #5 clk = ~clk;

   snax_csr_responder dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .csr_req_data_i  (req_data),
      .csr_req_addr_i  (req_addr),
      .csr_req_write_i (req_write),
      .csr_req_valid_i (req_valid),
      .csr_req_ready_o (req_ready),
      .csr_rsp_data_o  (rsp_data),
      .csr_rsp_valid_o (rsp_valid),
      .csr_rsp_ready_i (rsp_ready),
      .csr_rw_o        (rw_o),
      .csr_ro_i        (ro),
      .acc_start_o     (start),
      .acc_busy_i      (busy)
   );

   int n_chk = 0, n_pass = 0, n_fail = 0;
   int n_start_seen = 0;

   // Reference model state
   int          m_phase;
   logic [31:0] m_cnt;
   logic [31:0] m_rw [8];
   bit          m_rv;
   logic [31:0] m_rdata;
   logic [31:0] exp_q [$];
   bit          m_init = 1'b0;
   bit          m_acc;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (a < 32'd8)   return m_rw[a[2:0]];
      if (a < 32'd10)  return ro[(int'(a) - 8)*32 +: 32];
      if (a == 32'd10) return {30'b0, m_phase == M_RUN, m_phase != M_IDLE};
      if (a == 32'd11) return m_cnt;
      return 32'h0;
   endfunction

   function automatic logic [255:0] pack_rw();
      logic [255:0] p;
      for (int i = 0; i < 8; i++) p[i*32 +: 32] = m_rw[i];
      return p;
   endfunction

   // One clock cycle: drive at negedge, check outputs, advance the model to the next edge.
   task automatic step(input bit r, input bit v, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input bit rr, input bit b);
      bit          exp_ready, acc;
      logic [31:0] rv;
      @(negedge clk);
      rst = r; req_valid = v; req_write = w; req_addr = a; req_data = d;
      rsp_ready = rr; busy = b; ro = ro_nxt;
      #1;
      if (!w)                         exp_ready = !m_rv || rr;
      else if (a < 32'd8 || a == 32'd10) exp_ready = (m_phase == M_IDLE);
      else                            exp_ready = 1'b1;
      if (m_init) begin
         chk("req_ready", req_ready, exp_ready);
         chk("acc_start", start, m_phase == M_LAUNCH);
         chk("rsp_valid", rsp_valid, m_rv);
         chk("rsp_data", rsp_data, m_rdata);
         chk("csr_rw", rw_o, pack_rw());
      end
      if (start === 1'b1) n_start_seen++;
      acc = v && exp_ready;
      rv  = model_read(a);
      if (r) begin
         m_phase = M_IDLE; m_cnt = 0; m_rv = 0; m_rdata = 0;
         for (int i = 0; i < 8; i++) m_rw[i] = 0;
         exp_q.delete();
         m_init = 1'b1;
      end else begin
         if (m_rv && rr) chk("rsp_order", rsp_data, exp_q.pop_front());
         if (acc && !w) begin
            exp_q.push_back(rv);
            m_rv = 1'b1; m_rdata = rv;
         end else if (rr) begin
            m_rv = 1'b0;
         end
         if (acc && w && a < 32'd8) m_rw[a[2:0]] = d;
         case (m_phase)
            M_IDLE:   if (acc && w && a == 32'd10 && d[0]) m_phase = M_LAUNCH;
            M_LAUNCH: begin m_cnt = 0; m_phase = M_WAIT; end
            M_WAIT:   if (b) m_phase = M_RUN;
            default: begin
               if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
               if (!b) m_phase = M_IDLE;
            end
         endcase
      end
      m_acc = acc;
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int          ai, s0, sel;
      bit          rb, w, v, rr, r;
      logic [31:0] a, d;
      bit          pat [4];
      pat = '{1'b1, 1'b0, 1'b1, 1'b1};
      rst = 1'b1; req_valid = 0; req_write = 0; req_addr = 0; req_data = 0;
      rsp_ready = 0; busy = 0;
      ro_nxt = {32'h0000_1234, 32'h0000_5678};
      ro = ro_nxt;

      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      after_edge();
      chk("reset_rsp_valid", rsp_valid, 1'b0);
      chk("reset_rsp_data", rsp_data, 32'h0);
      chk("reset_rw", rw_o, 256'h0);

      // Write then read back addr 3
      step(0, 1, 1, 3, 32'hDEAD_BEEF, 1, 0);
      after_edge();
      chk("rw3_visible", rw_o[127:96], 32'hDEAD_BEEF);
      chk("write_no_rsp", rsp_valid, 1'b0);
      step(0, 1, 0, 3, 0, 1, 0);
      after_edge();
      chk("rd3_valid", rsp_valid, 1'b1);
      chk("rd3_data", rsp_data, 32'hDEAD_BEEF);

      // Back-to-back reads with a stalling consumer
      step(0, 1, 1, 0, 32'h11, 1, 0);
      step(0, 1, 1, 1, 32'h22, 1, 0);
      step(0, 1, 1, 2, 32'h33, 1, 0);
      ai = 0;
      for (int c = 0; c < 16 && ai < 4; c++) begin
         step(0, 1, 0, ai, 0, pat[c%4], 0);
         if (m_acc) ai++;
      end
      chk("b2b_all_accepted", ai, 4);
      step(0, 0, 0, 0, 0, 1, 0);

      // Launch and run
      s0 = n_start_seen;
      step(0, 1, 1, 10, 1, 1, 0);
      step(0, 0, 0, 0, 0, 1, 0);
      step(0, 1, 0, 10, 0, 1, 0);
      after_edge();
      chk("ctrl_wait", rsp_data, 32'h1);
      step(0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 1, 1);
      step(0, 1, 0, 10, 0, 1, 1);
      after_edge();
      chk("ctrl_run", rsp_data, 32'h3);
      step(0, 1, 1, 0, 32'hAAAA, 1, 1);
      chk("run_wr_blocked", req_ready, 1'b0);
      step(0, 1, 0, 0, 0, 1, 1);
      chk("run_rd_ready", req_ready, 1'b1);
      step(0, 1, 1, 0, 32'hAAAA, 1, 1);
      step(0, 1, 1, 0, 32'hAAAA, 1, 0);
      chk("run_wr_blocked2", req_ready, 1'b0);
      step(0, 1, 1, 0, 32'hAAAA, 1, 0);
      chk("idle_wr_ready", req_ready, 1'b1);
      after_edge();
      chk("rw0_after_run", rw_o[31:0], 32'hAAAA);
      step(0, 1, 0, 11, 0, 1, 0);
      after_edge();
      chk("run_count", rsp_data, 32'd5);
      step(0, 1, 0, 10, 0, 1, 0);
      after_edge();
      chk("ctrl_idle", rsp_data, 32'h0);
      chk("start_pulses", n_start_seen - s0, 1);

      // Status and out-of-range addresses
      step(0, 1, 0, 9, 0, 1, 0);
      after_edge();
      chk("ro_read", rsp_data, 32'h1234);
      step(0, 1, 0, 50, 0, 1, 0);
      after_edge();
      chk("oor_read", rsp_data, 32'h0);
      step(0, 1, 1, 50, 32'hFFFF_FFFF, 1, 0);
      chk("oor_wr_ready", req_ready, 1'b1);
      after_edge();
      chk("oor_write", rw_o, pack_rw());

      // Reset while waiting for busy with a response pending
      step(0, 1, 1, 10, 1, 1, 0);
      step(0, 0, 0, 0, 0, 1, 0);
      step(0, 1, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      after_edge();
      chk("rst_rsp_dropped", rsp_valid, 1'b0);
      chk("rst_rw_cleared", rw_o, 256'h0);
      chk("rst_no_start", start, 1'b0);
      s0 = n_start_seen;
      step(0, 0, 0, 0, 0, 1, 0);
      step(0, 1, 0, 10, 0, 1, 1);
      after_edge();
      chk("rst_ctrl_idle", rsp_data, 32'h0);
      step(0, 0, 0, 0, 0, 1, 0);
      chk("rst_no_pulse", n_start_seen - s0, 0);

      // Random traffic
      rb = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         sel = $urandom_range(0, 15);
         case (sel)
            12:      a = 32'd50;
            13:      a = 32'h8000_0003;
            14:      a = 32'hFFFF_FFFF;
            15:      a = 32'd10;
            default: a = 32'(sel);
         endcase
         w  = ($urandom_range(0, 1) == 1);
         v  = ($urandom_range(0, 3) != 0);
         rr = ($urandom_range(0, 3) != 0);
         d  = $urandom;
         if ($urandom_range(0, 5) == 0) rb = !rb;
         r  = ($urandom_range(0, 299) == 0);
         if (i % 50 == 0) ro_nxt = {$urandom, $urandom};
         step(r, v, w, a, d, rr, rb);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/snax_csr_responder.md
Name: snax_csr_responder

Overview:
- CSR-side endpoint of the simplified CSR request/response protocol. It receives the CSR requests produced by the SNAX-side translator and owns the accelerator's configuration register bank.
- It serves reads through a 1-entry response register and launches the accelerator through a control CSR.
- It tracks run state with an FSM and exposes a run-cycle counter.
- It sits between the translator and the accelerator datapath, inside the accelerator shell.

Parameters:
- NumRwCsr, 8, number of read/write configuration CSRs, at addresses 0..NumRwCsr-1.
- NumRoCsr, 2, number of read-only status CSRs from the accelerator, at addresses NumRwCsr..NumRwCsr+NumRoCsr-1.
- DataWidth, 32, CSR data width.
- Derived, not overridable: CtrlAddr = NumRwCsr+NumRoCsr; CntAddr = CtrlAddr+1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- csr_req_data_i  in  32  write data.
- csr_req_addr_i  in  32  CSR index; already offset-corrected upstream.
- csr_req_write_i  in  1  1 = write, 0 = read.
- csr_req_valid_i  in  1  request valid.
- csr_req_ready_o  out  1  request accepted when valid&ready.
- csr_rsp_data_o  out  32  read data.
- csr_rsp_valid_o  out  1  response valid.
- csr_rsp_ready_i  in  1  response consumed.
- csr_rw_o  out  NumRwCsr*32  flattened RW CSR values; CSR k occupies bits [32k+31:32k].
- csr_ro_i  in  NumRoCsr*32  flattened status values from the accelerator.
- acc_start_o  out  1  one-cycle launch pulse.
- acc_busy_i  in  1  accelerator running.

Behaviour:

Reset (rst_i sampled high on a clock edge):
- All RW CSRs = 0, csr_rsp_valid_o = 0, csr_rsp_data_o = 0, acc_start_o = 0, FSM = IDLE, run counter = 0.
- Reset mid-transaction drops any pending response and aborts the FSM; no start pulse follows.

Address decode (full 32-bit compare):
- RW range, RO range, CtrlAddr, CntAddr.
- Anything else is out-of-range: writes are dropped, reads return 0.

Writes:
- Writes never produce a response.
- RW address: register updates on the accept edge and is visible on csr_rw_o the next cycle.
- RO address or CntAddr: accepted, no effect.
- CtrlAddr with data[0]=1: launch (FSM IDLE->LAUNCH). Data[0]=0: no effect.

Reads:
- Exactly one response per accepted read. Latency 1: a read accepted at edge N gives csr_rsp_valid_o=1 after edge N, with data sampled at N.
- Read data by address:
  - RW: register value.
  - RO: csr_ro_i slice.
  - CtrlAddr: {30'b0, state==RUN, state!=IDLE}.
  - CntAddr: run counter.
- csr_rsp_valid_o/csr_rsp_data_o hold stable until csr_rsp_ready_i; valid clears on the consume edge unless a new read is accepted on the same edge.

csr_req_ready_o (combinational, from state and addr/write):
- Reads: ready = !csr_rsp_valid_o || csr_rsp_ready_i, so back-to-back reads run at full throughput.
- Writes to an RW address or CtrlAddr: ready = (state==IDLE). The bank is locked while the accelerator is launching or running.
- All other writes: ready = 1.

FSM:
- IDLE: on launch go to LAUNCH.
- LAUNCH: acc_start_o=1 for exactly this cycle; run counter cleared; go to WAIT_BUSY.
- WAIT_BUSY: go to RUN when acc_busy_i=1. There is no timeout; reset is the only escape.
- RUN: go to IDLE when acc_busy_i=0.

Run counter:
- 32-bit; increments by 1 each cycle in RUN.
- Saturates at 0xFFFF_FFFF.
- Holds its value in IDLE until the next launch.

Simultaneous events:
- Read of CtrlAddr in the launch-accept cycle returns the pre-launch status (0).
- acc_busy_i already high in LAUNCH is ignored; the RUN transition happens only from WAIT_BUSY.

Test Plan:
- Write 0xDEAD_BEEF to addr 3, then read addr 3 with rsp_ready=1 -> csr_rw_o[127:96]=0xDEAD_BEEF one cycle after the write; rsp_valid one cycle after the read accept with data 0xDEAD_BEEF; no response for the write.
- Four back-to-back reads (addrs 0..3) with rsp_ready toggling 1,0,1,1 -> req_ready low exactly while rsp_valid=1 and rsp_ready=0; responses arrive in order with no loss or duplicate.
- Write 1 to CtrlAddr (10), hold busy low 3 cycles, then high 5 cycles, then low -> acc_start_o high exactly 1 cycle; CtrlAddr reads 0b01 then 0b11 then 0b00; CntAddr reads 5.
- During RUN, write addr 0 -> req_ready=0 until FSM returns to IDLE, then accepted; a read of addr 0 during RUN is accepted immediately.
- Read addr 9 with csr_ro_i slice = 0x1234 -> 0x1234. Read addr 50 -> 0. Write addr 50 -> accepted with no effect on any register.
- Assert rst_i in WAIT_BUSY with a response pending -> next cycle rsp_valid=0, FSM IDLE, all csr_rw_o=0, no start pulse.
